// File: rtl/spw_pkg.sv
// Shared SpaceWire definitions: codec CURRENTSTATE encoding and link-manager FSM states.
package spw_pkg;

  typedef enum logic [2:0] {
    CS_ERROR_RESET = 3'd0,
    CS_ERROR_WAIT  = 3'd1,
    CS_READY       = 3'd2,
    CS_STARTED     = 3'd3,
    CS_CONNECTING  = 3'd4,
    CS_RUN         = 3'd5
  } codec_state_e;

  typedef enum logic [2:0] {
    LM_IDLE,
    LM_START,
    LM_WAIT_RUN,
    LM_RUN,
    LM_BACKOFF,
    LM_FAIL
  } lm_state_e;

  localparam int DATA_W = 9;

  // Bit 8 set marks the last word of a packet (EOP/EEP).
  function automatic logic is_eop(input logic [DATA_W-1:0] word);
    return word[DATA_W-1];
  endfunction

endpackage

// File: rtl/spw_tx_arb.sv
// Two-requester transmit arbiter: packet-atomic ownership, round-robin between packets,
// at most one codec write every two cycles.
module spw_tx_arb
  import spw_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   link_ok,
  input  logic                   tx_full,
  input  logic [1:0]             req,
  input  logic [1:0][DATA_W-1:0] data,
  output logic [1:0]             ack,
  output logic                   wr_data,
  output logic [DATA_W-1:0]      data_i
);

  logic              owned_reg, owned_next;
  logic              owner_reg, owner_next;
  logic              prio_reg, prio_next;
  logic              wr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              can_accept;
  logic              grant_valid;
  logic              grant_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = prio_reg;
    can_accept  = link_ok && !tx_full && !wr_reg;
    if (can_accept) begin
      if (owned_reg) begin
        // Mid-packet: only the owner may send, even if it is momentarily idle.
        grant_idx   = owner_reg;
        grant_valid = req[owner_reg];
      end else if (req[prio_reg]) begin
        grant_idx   = prio_reg;
        grant_valid = 1'b1;
      end else if (req[~prio_reg]) begin
        grant_idx   = ~prio_reg;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    owned_next = owned_reg;
    owner_next = owner_reg;
    prio_next  = prio_reg;
    if (!link_ok) begin
      owned_next = 1'b0;
    end else if (grant_valid) begin
      owner_next = grant_idx;
      prio_next  = ~grant_idx;
      owned_next = !is_eop(data[grant_idx]);
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack[gi] = grant_valid && (grant_idx == (gi == 1));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owned_reg <= 1'b0;
      owner_reg <= 1'b0;
      prio_reg  <= 1'b0;
      wr_reg    <= 1'b0;
      data_reg  <= '0;
    end else begin
      owned_reg <= owned_next;
      owner_reg <= owner_next;
      prio_reg  <= prio_next;
      wr_reg    <= grant_valid;
      if (grant_valid) begin
        data_reg <= data[grant_idx];
      end
    end
  end

  assign wr_data = wr_reg;
  assign data_i  = data_reg;

endmodule

// File: rtl/spw_link_mgr.sv
// SpaceWire link manager: start/retry/backoff FSM around the codec, clock-divider select,
// and the shared transmit arbiter for requesters A and B.
module spw_link_mgr
  import spw_pkg::*;
#(
  parameter logic [6:0] INIT_DIV    = 7'd19,
  parameter int         RUN_TIMEOUT = 12800,
  parameter int         BACKOFF     = 25600,
  parameter int         MAX_RETRIES = 4
) (
  input  logic              CLOCK,
  input  logic              RESETn,
  input  logic              ENABLE,
  input  logic [6:0]        RUN_DIV,
  input  logic [2:0]        CURRENTSTATE,
  input  logic              TX_FULL,
  output logic              LINK_START,
  output logic              LINK_DISABLE,
  output logic              AUTOSTART,
  output logic [6:0]        TX_CLK_DIV,
  output logic              WR_DATA,
  output logic [DATA_W-1:0] DATA_I,
  input  logic              REQ_A,
  input  logic [DATA_W-1:0] DATA_A,
  output logic              ACK_A,
  input  logic              REQ_B,
  input  logic [DATA_W-1:0] DATA_B,
  output logic              ACK_B,
  output logic              LINK_UP,
  output logic              FAILED,
  output logic [2:0]        RETRY_CNT,
  output logic              LINK_LOST
);

  // Timers count load..0, so a state lasts exactly its parameter in cycles.
  localparam logic [15:0] RUN_TO_LOAD  = 16'(RUN_TIMEOUT - 1);
  localparam logic [15:0] BACKOFF_LOAD = 16'(BACKOFF - 1);
  localparam logic [2:0]  RETRY_MAX    = 3'(MAX_RETRIES);

  lm_state_e   state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic [2:0]  retry_reg, retry_next, retry_inc;
  logic [6:0]  div_reg;
  logic        lost_reg;
  logic        timer_done;
  logic        codec_run;
  logic        link_ok;
  logic [1:0]  arb_ack;

  assign timer_done = (timer_reg == 16'd0);
  assign codec_run  = (CURRENTSTATE == CS_RUN);
  assign retry_inc  = (retry_reg == RETRY_MAX) ? retry_reg : retry_reg + 3'd1;

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    if (!ENABLE) begin
      state_next = LM_IDLE;
    end else begin
      case (state_reg)
        LM_IDLE: begin
          state_next = LM_START;
          retry_next = '0;
        end
        LM_START:    state_next = LM_WAIT_RUN;
        LM_WAIT_RUN: begin
          if (codec_run) begin
            state_next = LM_RUN;
          end else if (timer_done) begin
            retry_next = retry_inc;
            state_next = (retry_inc == RETRY_MAX) ? LM_FAIL : LM_BACKOFF;
          end
        end
        LM_RUN:      if (!codec_run) state_next = LM_BACKOFF;
        LM_BACKOFF:  if (timer_done) state_next = LM_START;
        LM_FAIL:     state_next = LM_FAIL;
        default:     state_next = LM_IDLE;
      endcase
    end
  end

  always_comb begin
    timer_next = timer_done ? timer_reg : timer_reg - 16'd1;
    if (state_next != state_reg) begin
      if (state_next == LM_WAIT_RUN) begin
        timer_next = RUN_TO_LOAD;
      end else if (state_next == LM_BACKOFF) begin
        timer_next = BACKOFF_LOAD;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg <= LM_IDLE;
      timer_reg <= '0;
      retry_reg <= '0;
      div_reg   <= INIT_DIV;
      lost_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      retry_reg <= retry_next;
      div_reg   <= (state_reg == LM_RUN) ? RUN_DIV : INIT_DIV;
      lost_reg  <= (state_reg == LM_RUN) && (state_next == LM_BACKOFF);
    end
  end

  // The arbiter only accepts when the link stays in Run through the write cycle.
  assign link_ok = (state_reg == LM_RUN) && (state_next == LM_RUN);

  spw_tx_arb u_arb (
    .clk     (CLOCK),
    .rst_n   (RESETn),
    .link_ok (link_ok),
    .tx_full (TX_FULL),
    .req     ({REQ_B, REQ_A}),
    .data    ({DATA_B, DATA_A}),
    .ack     (arb_ack),
    .wr_data (WR_DATA),
    .data_i  (DATA_I)
  );

  assign ACK_A        = arb_ack[0];
  assign ACK_B        = arb_ack[1];
  assign LINK_START   = (state_reg == LM_START) || (state_reg == LM_WAIT_RUN) || (state_reg == LM_RUN);
  assign LINK_DISABLE = ~LINK_START;
  assign AUTOSTART    = 1'b0;
  assign TX_CLK_DIV   = div_reg;
  assign LINK_UP      = (state_reg == LM_RUN);
  assign FAILED       = (state_reg == LM_FAIL);
  assign RETRY_CNT    = retry_reg;
  assign LINK_LOST    = lost_reg;

endmodule

// File: tb/tb_spw_link_mgr.sv
// Self-checking bench for spw_link_mgr: FSM vector table, retry/fail, packet arbitration
// corner cases, link loss, async reset and a randomized arbiter run against a reference model.
module tb_spw_link_mgr;

  localparam int         RT = 20;
  localparam int         BO = 30;
  localparam int         MR = 4;
  localparam logic [6:0] RDIV = 7'd3;

  logic       CLOCK, RESETn, ENABLE, TX_FULL;
  logic [6:0] RUN_DIV;
  logic [2:0] CURRENTSTATE;
  logic       LINK_START, LINK_DISABLE, AUTOSTART, WR_DATA;
  logic [6:0] TX_CLK_DIV;
  logic [8:0] DATA_I, DATA_A, DATA_B;
  logic       REQ_A, REQ_B, ACK_A, ACK_B;
  logic       LINK_UP, FAILED, LINK_LOST;
  logic [2:0] RETRY_CNT;

  spw_link_mgr #(
    .INIT_DIV(7'd19), .RUN_TIMEOUT(RT), .BACKOFF(BO), .MAX_RETRIES(MR)
  ) dut (
    .CLOCK(CLOCK), .RESETn(RESETn), .ENABLE(ENABLE), .RUN_DIV(RUN_DIV),
    .CURRENTSTATE(CURRENTSTATE), .TX_FULL(TX_FULL), .LINK_START(LINK_START),
    .LINK_DISABLE(LINK_DISABLE), .AUTOSTART(AUTOSTART), .TX_CLK_DIV(TX_CLK_DIV),
    .WR_DATA(WR_DATA), .DATA_I(DATA_I), .REQ_A(REQ_A), .DATA_A(DATA_A), .ACK_A(ACK_A),
    .REQ_B(REQ_B), .DATA_B(DATA_B), .ACK_B(ACK_B), .LINK_UP(LINK_UP), .FAILED(FAILED),
    .RETRY_CNT(RETRY_CNT), .LINK_LOST(LINK_LOST)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESETn = 1'b0; ENABLE = 1'b0; CURRENTSTATE = 3'd0; TX_FULL = 1'b0; RUN_DIV = RDIV;
    REQ_A = 1'b0; REQ_B = 1'b0; DATA_A = '0; DATA_B = '0;
    #7;
    RESETn = 1'b1;
    tick(1);
  endtask

  task automatic check_reset_vals(input string name);
    check(name, int'({LINK_START, LINK_DISABLE, AUTOSTART, TX_CLK_DIV, WR_DATA, DATA_I,
                      ACK_A, ACK_B, LINK_UP, FAILED, RETRY_CNT, LINK_LOST}),
          int'({1'b0, 1'b1, 1'b0, 7'd19, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0}));
  endtask

  task automatic go_run();
    ENABLE = 1'b1; CURRENTSTATE = 3'd5;
    tick(3);
    check("link_up_reached", LINK_UP, 1);
  endtask

  // Packet scenario: A sends 011,022,1FF while B holds one word 155; optional TX_FULL window.
  logic [8:0] got_q[$];
  int bad_ack, bad_wr;

  task automatic run_packets(input int full_len);
    int ia, ib, full_left;
    bit full_done, prev_full;
    logic [8:0] pa [3];
    pa = '{9'h011, 9'h022, 9'h1FF};
    ia = 0; ib = 0; full_left = 0; full_done = 0; prev_full = 0;
    got_q.delete(); bad_ack = 0; bad_wr = 0;
    for (int c = 0; c < 120 && got_q.size() < 4; c++) begin
      if (WR_DATA) begin
        got_q.push_back(DATA_I);
        if (prev_full) bad_wr++;
      end
      if (!full_done && full_len > 0 && got_q.size() == 1) begin
        full_done = 1; full_left = full_len;
      end
      TX_FULL = (full_left > 0);
      REQ_A = (ia < 3); DATA_A = (ia < 3) ? pa[ia] : 9'h000;
      REQ_B = (ib < 1); DATA_B = 9'h155;
      #1;
      if (TX_FULL && (ACK_A || ACK_B)) bad_ack++;
      if (ACK_A) ia++;
      if (ACK_B) ib++;
      prev_full = TX_FULL;
      if (full_left > 0) full_left--;
      tick(1);
    end
    TX_FULL = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
  endtask

  task automatic check_packets(input string tag);
    logic [8:0] exp_seq [4];
    exp_seq = '{9'h011, 9'h022, 9'h1FF, 9'h155};
    check({tag, "_count"}, got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), got_q[i], exp_seq[i]);
  endtask

  typedef struct {
    logic       en;
    logic [2:0] cs;
    int         n;
    logic       start, dis, up, fail, lost;
    logic [6:0] div;
    logic [2:0] retry;
  } vec_t;

  vec_t tbl [11];

  // Randomized arbiter model state (described as packet owner / last-served requester).
  int         pkt_owner, last_served, winner;
  bit         exp_wr, full_r;
  logic [8:0] exp_word;
  bit         r_req [2];
  logic [8:0] r_data [2];

  initial begin
    //           en   cs    n  start dis  up   fail lost div    retry
    tbl[0]  = '{1'b0, 3'd0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd19, 3'd0}; // idle
    tbl[1]  = '{1'b1, 3'd0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd19, 3'd0}; // start
    tbl[2]  = '{1'b1, 3'd0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd19, 3'd0}; // wait_run
    tbl[3]  = '{1'b1, 3'd5, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd19, 3'd0}; // run entry
    tbl[4]  = '{1'b1, 3'd5, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, RDIV,  3'd0}; // run div
    tbl[5]  = '{1'b1, 3'd0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RDIV,  3'd0}; // lost
    tbl[6]  = '{1'b1, 3'd0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd19, 3'd0}; // backoff
    tbl[7]  = '{1'b0, 3'd0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd19, 3'd0}; // disable
    tbl[8]  = '{1'b1, 3'd3, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd19, 3'd0}; // wait_run
    tbl[9]  = '{1'b0, 3'd5, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'd19, 3'd0}; // enable wins
    tbl[10] = '{1'b1, 3'd5, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd19, 3'd0}; // run again

    do_reset();
    check_reset_vals("reset_state");

    for (int i = 0; i < 11; i++) begin
      ENABLE = tbl[i].en; CURRENTSTATE = tbl[i].cs;
      tick(tbl[i].n);
      check($sformatf("fsm_vec%0d", i),
            int'({LINK_START, LINK_DISABLE, LINK_UP, FAILED, LINK_LOST, AUTOSTART, TX_CLK_DIV, RETRY_CNT}),
            int'({tbl[i].start, tbl[i].dis, tbl[i].up, tbl[i].fail, tbl[i].lost, 1'b0, tbl[i].div, tbl[i].retry}));
    end

    // Stuck in Started: one START cycle + RT waiting + BO backoff per failed attempt.
    begin
      int seen;
      logic [2:0] prev;
      ENABLE = 1'b0; tick(1);
      ENABLE = 1'b1; CURRENTSTATE = 3'd3;
      seen = 0; prev = 3'd0;
      for (int k = 1; k <= 400 && !FAILED; k++) begin
        tick(1);
        if (RETRY_CNT != prev) begin
          seen++; prev = RETRY_CNT;
          check($sformatf("retry_value%0d", seen), RETRY_CNT, seen);
          check($sformatf("retry_time%0d", seen), k, 2 + RT + (seen - 1) * (RT + BO + 1));
          check($sformatf("failed_at_retry%0d", seen), FAILED, int'(seen == MR));
        end
      end
      check("failed_reached", FAILED, 1);
      ENABLE = 1'b0; tick(1);
      check("fail_to_idle", int'({FAILED, LINK_DISABLE, LINK_START}), int'(3'b010));
    end

    do_reset(); go_run();
    run_packets(0);
    check_packets("pkt");

    do_reset(); go_run();
    run_packets(20);
    check_packets("full_pkt");
    check("full_no_ack", bad_ack, 0);
    check("full_no_wr", bad_wr, 0);

    // Codec drops out of Run right after A's first (non-EOP) word is accepted.
    do_reset(); go_run();
    REQ_A = 1'b1; DATA_A = 9'h011; #1;
    check("lost_first_ack", ACK_A, 1);
    tick(1);
    DATA_A = 9'h022; REQ_B = 1'b1; DATA_B = 9'h155; CURRENTSTATE = 3'd0;
    check("lost_last_wr", int'({WR_DATA, DATA_I}), int'({1'b1, 9'h011}));
    tick(1);
    check("lost_pulse", int'({LINK_LOST, WR_DATA, LINK_UP}), int'(3'b100));
    tick(1);
    check("lost_pulse_end", LINK_LOST, 0);
    check("lost_div_init", TX_CLK_DIV, 19);
    CURRENTSTATE = 3'd5; bad_wr = 0;
    for (int c = 0; c < 200 && !LINK_UP; c++) begin
      tick(1);
      if (WR_DATA) bad_wr++;
    end
    check("relink_up", LINK_UP, 1);
    check("relink_no_wr", bad_wr, 0);
    #1;
    check("relink_b_first", int'({ACK_A, ACK_B}), int'(2'b01));
    tick(1);
    check("relink_b_word", int'({WR_DATA, DATA_I}), int'({1'b1, 9'h155}));
    REQ_A = 1'b0; REQ_B = 1'b0;

    // Asynchronous reset while waiting for Run on the second attempt.
    do_reset();
    ENABLE = 1'b1; CURRENTSTATE = 3'd3;
    tick(RT + BO + 5);
    check("pre_rst_state", int'({LINK_START, RETRY_CNT}), int'({1'b1, 3'd1}));
    REQ_A = 1'b1;
    #2;
    RESETn = 1'b0;
    #1;
    check_reset_vals("async_reset");
    #10;
    RESETn = 1'b1;
    tick(1);

    // Randomized arbitration against the reference model, link held in Run.
    do_reset(); go_run();
    pkt_owner = -1; last_served = 1; exp_wr = 0; exp_word = '0;
    r_req[0] = 0; r_req[1] = 0; r_data[0] = '0; r_data[1] = '0;
    for (int c = 0; c < 600; c++) begin
      check("rnd_wr", WR_DATA, int'(exp_wr));
      if (exp_wr) check("rnd_data", DATA_I, exp_word);
      for (int i = 0; i < 2; i++) begin
        if (!r_req[i] && $urandom_range(0, 2) == 0) begin
          r_req[i]     = 1;
          r_data[i]    = 9'($urandom);
          r_data[i][8] = ($urandom_range(0, 3) == 0);
        end
      end
      full_r = ($urandom_range(0, 4) == 0);
      TX_FULL = full_r;
      REQ_A = r_req[0]; DATA_A = r_data[0];
      REQ_B = r_req[1]; DATA_B = r_data[1];
      #1;
      winner = -1;
      if (!full_r && !exp_wr) begin
        if (pkt_owner >= 0) begin
          if (r_req[pkt_owner]) winner = pkt_owner;
        end else if (r_req[1 - last_served]) begin
          winner = 1 - last_served;
        end else if (r_req[last_served]) begin
          winner = last_served;
        end
      end
      check("rnd_ack_a", ACK_A, int'(winner == 0));
      check("rnd_ack_b", ACK_B, int'(winner == 1));
      exp_wr = (winner >= 0);
      if (winner >= 0) begin
        exp_word    = r_data[winner];
        last_served = winner;
        pkt_owner   = r_data[winner][8] ? -1 : winner;
        r_req[winner] = 0;
      end
      tick(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
